sr_refresh_ctrl: RTL and testbench

- Parametrised successor to the single-bank smart-refresh tracker for the GC-DRAM controller.
- Keeps one "fresh" bit per row, set by user writes. A sweep walks every row and skips rows whose fresh bit is set (skip mode). It issues a valid/ready refresh request for every other row.
- Sweeps start on a manual pulse or from an internal retention timer.
- Sits between the user write port and the refresh execution engine in controller_advanced_refresh.

---
 rtl/sr_pkg.sv | 10 +
 rtl/sr_ret_timer.sv | 17 +
 rtl/sr_refresh_ctrl.sv | 89 ++++++++
 tb/tb_sr_refresh_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared state encoding and width helpers for the smart-refresh tracker
package sr_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} sr_state_t;
    function automatic int addr_width(input int rows);
        return rows > 2 ? $clog2(rows) : 1;
    endfunction
    function automatic int cnt_width(input int rows);
        return $clog2(rows + 1);
    endfunction
endpackage

// File: rtl/sr_ret_timer.sv
// sr_ret_timer: free-running retention timer, expire marks the wrap cycle
module sr_ret_timer #(
    parameter int RET_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(RET_CYCLES);
    logic [W-1:0] cnt;
    assign expire = en && cnt == W'(RET_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst || !en) cnt <= '0;
        else cnt <= expire ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/sr_refresh_ctrl.sv
// sr_refresh_ctrl: per-row fresh bitmap with a skip-mode refresh sweep and valid/ready request port
module sr_refresh_ctrl
    import sr_pkg::*;
#(
    parameter int ROWS       = 128,
    parameter int ADDR_W     = addr_width(ROWS),
    parameter int CNT_W      = cnt_width(ROWS),
    parameter int RET_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto_en,
    input  logic              skip_en,
    input  logic [ADDR_W-1:0] addr_user,
    input  logic              user_write_enable,
    output logic              indicator_user,
    output logic              ref_valid,
    input  logic              ref_ready,
    output logic [ADDR_W-1:0] addr_ref,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  refreshed_cnt,
    output logic [CNT_W-1:0]  skipped_cnt,
    output logic              overrun
);
    // bitmap padded to the full address space so any addr_user indexes safely
    localparam int DEPTH = 1 << ADDR_W;
    sr_state_t state, state_nxt;
    logic [DEPTH-1:0] fresh, fresh_nxt;
    logic [ADDR_W-1:0] ptr;
    logic expire, trigger, last, skip, fire;
    sr_ret_timer #(.RET_CYCLES(RET_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (auto_en),
        .expire (expire)
    );
    assign trigger        = start || expire;
    assign last           = ptr == ADDR_W'(ROWS - 1);
    assign skip           = state == SCAN && skip_en && fresh[ptr];
    assign fire           = state == ISSUE && ref_ready;
    assign indicator_user = fresh[addr_user];
    assign addr_ref       = ptr;
    always_comb begin
        state_nxt = state == IDLE  ? (trigger ? SCAN : IDLE)
                  : state == SCAN  ? (skip ? (last ? DONE : SCAN) : ISSUE)
                  : state == ISSUE ? (fire ? (last ? DONE : SCAN) : ISSUE)
                  : IDLE;
    end
    // a user write landing on the row being cleared wins
    always_comb begin
        fresh_nxt = fresh;
        if (skip || fire) fresh_nxt[ptr] = 1'b0;
        if (user_write_enable) fresh_nxt[addr_user] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            fresh         <= '0;
            ptr           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ref_valid     <= 1'b0;
            refreshed_cnt <= '0;
            skipped_cnt   <= '0;
            overrun       <= 1'b0;
        end else begin
            state     <= state_nxt;
            fresh     <= fresh_nxt;
            busy      <= state_nxt == SCAN || state_nxt == ISSUE;
            done      <= state_nxt == DONE;
            ref_valid <= state_nxt == ISSUE;
            if (state == IDLE && trigger) begin
                ptr           <= '0;
                refreshed_cnt <= '0;
                skipped_cnt   <= '0;
                overrun       <= 1'b0;
            end else if ((skip || fire) && !last) begin
                ptr <= ptr + 1'b1;
            end else if (state == DONE) begin
                ptr <= '0;
            end
            if (skip) skipped_cnt <= skipped_cnt + 1'b1;
            if (fire) refreshed_cnt <= refreshed_cnt + 1'b1;
            if (expire && busy) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sr_refresh_ctrl.sv
// tb_sr_refresh_ctrl: scoreboard bench with a row-set reference model of each sweep
module tb_sr_refresh_ctrl;
    localparam int ROWS = 8, RET = 64, AW = 3, CW = 4;
    logic clk = 0, rst = 0, start = 0, auto_en = 0, skip_en = 0;
    logic user_write_enable = 0, ref_ready = 0;
    logic [AW-1:0] addr_user = '0;
    logic indicator_user, ref_valid, busy, done, overrun;
    logic [AW-1:0] addr_ref;
    logic [CW-1:0] refreshed_cnt, skipped_cnt;
    int checks = 0, failures = 0;
    bit mfresh [ROWS];
    int exp_addr_q[$], exp_ref_q[$], exp_skp_q[$];

    sr_refresh_ctrl #(.ROWS(ROWS), .RET_CYCLES(RET)) dut (
        .clk(clk), .rst(rst), .start(start), .auto_en(auto_en), .skip_en(skip_en),
        .addr_user(addr_user), .user_write_enable(user_write_enable),
        .indicator_user(indicator_user), .ref_valid(ref_valid), .ref_ready(ref_ready),
        .addr_ref(addr_ref), .busy(busy), .done(done), .refreshed_cnt(refreshed_cnt),
        .skipped_cnt(skipped_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // a sweep visits every row once: fresh rows are skipped in skip mode, all end cleared
    task automatic plan_sweep(input bit sk, output int nr, output int ns);
        nr = 0;
        ns = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (sk && mfresh[r]) ns++;
            else begin
                exp_addr_q.push_back(r);
                nr++;
            end
            mfresh[r] = 0;
        end
        exp_ref_q.push_back(nr);
        exp_skp_q.push_back(ns);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ref_valid) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ref_unexpected: addr_ref=%0d with no request expected", addr_ref);
                end else begin
                    chk("ref_addr", int'(addr_ref), exp_addr_q[0]);
                    if (ref_ready) void'(exp_addr_q.pop_front());
                end
            end
            if (done) begin
                if (exp_ref_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: done pulse with no sweep expected");
                end else begin
                    chk("done_refreshed", int'(refreshed_cnt), exp_ref_q.pop_front());
                    chk("done_skipped", int'(skipped_cnt), exp_skp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!done && n < 3000) begin
            tick;
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: no done pulse within %0d cycles", name, n);
        end
        tick;
    endtask

    task automatic run_sweep(input bit sk, input int pct, input int stall_row, input int hit_row,
                             output int lat, output int nr, output int ns);
        int stalls = 0;
        plan_sweep(sk, nr, ns);
        skip_en = sk;
        start = 1;
        ref_ready = ($urandom_range(0, 99) < pct);
        tick;
        start = 0;
        lat = 1;
        chk("busy_after_start", int'(busy), 1);
        while (!done && lat < 3000) begin
            ref_ready = ($urandom_range(0, 99) < pct);
            if (stalls > 0 && stalls < 5) begin
                chk("stall_valid", int'(ref_valid), 1);
                chk("stall_addr", int'(addr_ref), stall_row);
                ref_ready = 0;
                stalls++;
            end else if (stalls == 0 && stall_row >= 0 && ref_valid && int'(addr_ref) == stall_row) begin
                ref_ready = 0;
                stalls = 1;
            end
            user_write_enable = 0;
            if (ref_valid && ref_ready && exp_addr_q.size() > 0 &&
                (hit_row == -2 ? $urandom_range(0, 3) == 0 : exp_addr_q[0] == hit_row)) begin
                addr_user = AW'(exp_addr_q[0]);
                user_write_enable = 1;
                mfresh[exp_addr_q[0]] = 1;
            end
            tick;
            lat++;
        end
        user_write_enable = 0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout: no done pulse within %0d cycles", lat);
        end
        tick;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_not_busy", int'(busy), 0);
    endtask

    initial begin
        int lat, nr, ns, n, dn, a, k, pct;
        bit sk;
        repeat (2) tick;
        chk("rst_ref_valid", int'(ref_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr_ref", int'(addr_ref), 0);
        chk("rst_refreshed", int'(refreshed_cnt), 0);
        chk("rst_skipped", int'(skipped_cnt), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1;
        for (int r = 0; r < ROWS; r++) begin
            addr_user = AW'(r);
            #1 chk("rst_indicator", int'(indicator_user), 0);
        end
        tick;

        run_sweep(0, 100, -1, -1, lat, nr, ns);
        chk("full_sweep_latency", lat, 17);

        addr_user = 3;
        user_write_enable = 1;
        mfresh[3] = 1;
        tick;
        addr_user = 5;
        mfresh[5] = 1;
        tick;
        user_write_enable = 0;
        run_sweep(1, 100, -1, -1, lat, nr, ns);
        chk("skip_sweep_latency", lat, 15);
        run_sweep(1, 100, -1, -1, lat, nr, ns);
        chk("second_sweep_latency", lat, 17);

        run_sweep(0, 100, 2, -1, lat, nr, ns);
        chk("stall_latency", lat, 22);

        run_sweep(0, 100, -1, 4, lat, nr, ns);
        addr_user = 4;
        #1 chk("hit_write_kept", int'(indicator_user), 1);
        run_sweep(1, 100, -1, -1, lat, nr, ns);
        chk("hit_row_skipped_latency", lat, 16);

        skip_en = 0;
        ref_ready = 0;
        auto_en = 1;
        n = 0;
        while (!busy && n < 200) begin
            tick;
            n++;
        end
        chk("auto_start_cycle", n, 64);
        plan_sweep(0, nr, ns);
        while (n < 127) begin
            tick;
            n++;
        end
        chk("overrun_before", int'(overrun), 0);
        tick;
        chk("overrun_after", int'(overrun), 1);
        auto_en = 0;
        ref_ready = 1;
        wait_done("auto_sweep", n);
        chk("overrun_sticky", int'(overrun), 1);
        run_sweep(0, 100, -1, -1, lat, nr, ns);
        chk("overrun_cleared", int'(overrun), 0);

        addr_user = 6;
        user_write_enable = 1;
        tick;
        addr_user = 7;
        tick;
        user_write_enable = 0;
        plan_sweep(0, nr, ns);
        skip_en = 0;
        ref_ready = 1;
        start = 1;
        tick;
        start = 0;
        n = 0;
        while (!(ref_valid && addr_ref == 3'd5) && n < 100) begin
            tick;
            n++;
        end
        chk("reach_row5", int'(addr_ref), 5);
        rst = 0;
        tick;
        chk("mid_rst_ref_valid", int'(ref_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_refreshed", int'(refreshed_cnt), 0);
        chk("mid_rst_skipped", int'(skipped_cnt), 0);
        chk("mid_rst_addr_ref", int'(addr_ref), 0);
        exp_addr_q.delete();
        exp_ref_q.delete();
        exp_skp_q.delete();
        for (int r = 0; r < ROWS; r++) mfresh[r] = 0;
        rst = 1;
        for (int r = 0; r < ROWS; r++) begin
            addr_user = AW'(r);
            #1 chk("mid_rst_indicator", int'(indicator_user), 0);
        end
        dn = 0;
        repeat (20) begin
            tick;
            dn += int'(done);
        end
        chk("mid_rst_no_done", dn, 0);

        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                a = $urandom_range(0, ROWS - 1);
                addr_user = AW'(a);
                user_write_enable = 1'($urandom_range(0, 1));
                #1 chk("ind_idle", int'(indicator_user), int'(mfresh[a]));
                if (user_write_enable) mfresh[a] = 1;
                tick;
            end
            user_write_enable = 0;
            sk = 1'($urandom_range(0, 1));
            pct = $urandom_range(0, 1) ? 100 : 60;
            run_sweep(sk, pct, -1, -2, lat, nr, ns);
            if (pct == 100) chk("rand_latency", lat, 2 * nr + ns + 1);
        end

        repeat (3) tick;
        chk("sb_drain", exp_addr_q.size() + exp_ref_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
